regwr_arbiter: RTL and testbench



---
 rtl/regwr_arbiter.sv | 156 +++++++++++++++
 tb/tb_regwr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regwr_arbiter.sv
// Two-requester register-file write-port arbiter with bounded lock bursts.
// Build option REGWR_ARB_RR_EN: round-robin tie-break in IDLE (default: A wins ties).
module regwr_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAXBURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reqA,
  input  logic          lockA,
  input  logic [AW-1:0] addrA,
  input  logic [DW-1:0] dataA,
  output logic          ackA,
  input  logic          reqB,
  input  logic          lockB,
  input  logic [AW-1:0] addrB,
  input  logic [DW-1:0] dataB,
  output logic          ackB,
  output logic          sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [1:0]    owner
);

  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAXBURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t        state, stateNext;
  logic [BW-1:0] bcnt, bcntNext, bcntInc;
  logic          grantA, grantB;
  logic          idleArb, pickB, lockWin;
  logic          tieB;

`ifdef REGWR_ARB_RR_EN
  logic rrPtr, rrPtrNext;  // 1: next tie goes to B

  assign tieB = rrPtr;

  // A grant that leaves the port un-owned, or a release without grant, ends
  // an ownership: the next tie goes to whoever was not just served.
  always_comb begin
    rrPtrNext = rrPtr;
    if (stateNext == IDLE) begin
      if (grantA)              rrPtrNext = 1'b1;
      else if (grantB)         rrPtrNext = 1'b0;
      else if (state == OWN_A) rrPtrNext = 1'b1;
      else if (state == OWN_B) rrPtrNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rrPtr <= 1'b0;
    else        rrPtr <= rrPtrNext;
  end
`else
  assign tieB = 1'b0;
`endif

  assign bcntInc = bcnt + BURST_ONE;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext = state;
    bcntNext  = bcnt;
    grantA    = 1'b0;
    grantB    = 1'b0;
    idleArb   = 1'b0;
    pickB     = 1'b0;
    lockWin   = 1'b0;

    unique case (state)
      OWN_A: begin
        if (reqA && bcnt < BURST_MAX) begin
          grantA   = 1'b1;
          bcntNext = bcntInc;
          if (!lockA || bcntInc == BURST_MAX) begin
            stateNext = IDLE;
            bcntNext  = '0;
          end
        end else begin
          stateNext = IDLE;
          bcntNext  = '0;
          idleArb   = 1'b1;
        end
      end
      OWN_B: begin
        if (reqB && bcnt < BURST_MAX) begin
          grantB   = 1'b1;
          bcntNext = bcntInc;
          if (!lockB || bcntInc == BURST_MAX) begin
            stateNext = IDLE;
            bcntNext  = '0;
          end
        end else begin
          stateNext = IDLE;
          bcntNext  = '0;
          idleArb   = 1'b1;
        end
      end
      default: idleArb = 1'b1;
    endcase

    // Released owners fall through to here, so the other side is served in the same cycle.
    if (idleArb && (reqA || reqB)) begin
      pickB   = reqB && (!reqA || tieB);
      grantA  = !pickB;
      grantB  = pickB;
      lockWin = pickB ? lockB : lockA;
      if (lockWin && MAXBURST > 1) begin
        stateNext = pickB ? OWN_B : OWN_A;
        bcntNext  = BURST_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcnt    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      sel     <= 1'b0;
    end else begin
      state <= stateNext;
      bcnt  <= bcntNext;
      wr_en <= (grantA && addrA != '0) || (grantB && addrB != '0);
      if (grantA) begin
        wr_addr <= addrA;
        wr_data <= dataA;
        sel     <= 1'b0;
      end else if (grantB) begin
        wr_addr <= addrB;
        wr_data <= dataB;
        sel     <= 1'b1;
      end
    end
  end

  assign ackA  = grantA && rst_n;
  assign ackB  = grantB && rst_n;
  assign owner = state;

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed bench for regwr_arbiter; follows the REGWR_ARB_RR_EN build for tie expectations.
module tb_regwr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MAXBURST = 4;
`ifdef REGWR_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reqA, lockA, reqB, lockB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dataA, dataB;
  logic          ackA, ackB, sel, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    owner;

  int compared   = 0;
  int mismatched = 0;

  regwr_arbiter #(.AW(AW), .DW(DW), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqA(reqA), .lockA(lockA), .addrA(addrA), .dataA(dataA), .ackA(ackA),
    .reqB(reqB), .lockB(lockB), .addrB(addrB), .dataB(dataB), .ackB(ackB),
    .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reqA = 1'b0; lockA = 1'b0; addrA = '0; dataA = '0;
    reqB = 1'b0; lockB = 1'b0; addrB = '0; dataB = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    reqA = 1'b1; reqB = 1'b1; addrA = 5'd7; dataA = '1;
    #2;
    compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    compared++; if (wr_addr !== '0) begin mismatched++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    compared++; if (wr_data !== '0) begin mismatched++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    compared++; if (sel !== 1'b0) begin mismatched++; $display("FAIL reset_sel got %b want 0", sel); end
    compared++; if (owner !== 2'b00) begin mismatched++; $display("FAIL reset_owner got %b want 00", owner); end
    compared++; if (ackA !== 1'b0 || ackB !== 1'b0) begin mismatched++; $display("FAIL reset_ack got %b%b want 00", ackA, ackB); end
    cyc();
    compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_edge_wr_en got %b want 0", wr_en); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    reqA = 1'b1; addrA = 5'b01110; dataA = 32'hDEAD_BEEF;
    @(negedge clk);
    compared++; if (ackA !== 1'b1 || ackB !== 1'b0) begin mismatched++; $display("FAIL single_ack got %b%b want 10", ackA, ackB); end
    cyc();
    reqA = 1'b0;
    @(negedge clk);
    compared++; if (wr_en !== 1'b1) begin mismatched++; $display("FAIL single_wr_en got %b want 1", wr_en); end
    compared++; if (wr_addr !== 5'b01110) begin mismatched++; $display("FAIL single_wr_addr got %b want 01110", wr_addr); end
    compared++; if (wr_data !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL single_wr_data got %h want deadbeef", wr_data); end
    compared++; if (sel !== 1'b0) begin mismatched++; $display("FAIL single_sel got %b want 0", sel); end
    compared++; if (ackA !== 1'b0) begin mismatched++; $display("FAIL single_idle_ack got %b want 0", ackA); end
    cyc();
    @(negedge clk);
    compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL single_hold_wr_en got %b want 0", wr_en); end
    compared++; if (wr_data !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL single_hold_wr_data got %h want deadbeef", wr_data); end
  endtask

  task automatic test_tie();
    bit          expB, prevB, gotA, gotB;
    int          eA, eB;
    logic [31:0] expData;
    do_reset();
    eA = 0; eB = 0; prevB = 1'b0; expData = '0;
    reqA = 1'b1; addrA = 5'd1; dataA = 32'hA000_0000;
    reqB = 1'b1; addrB = 5'd2; dataB = 32'hB000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      gotA = ackA; gotB = ackB;
      if (i > 0) begin
        compared++; if (sel !== prevB) begin mismatched++; $display("FAIL tie_sel[%0d] got %b want %b", i - 1, sel, prevB); end
        compared++; if (wr_data !== expData) begin mismatched++; $display("FAIL tie_wr_data[%0d] got %h want %h", i - 1, wr_data, expData); end
      end
      if (i < 4) begin
        expB = RR && (i % 2 == 1);
        compared++; if (ackA !== !expB || ackB !== expB) begin mismatched++; $display("FAIL tie_ack[%0d] got %b%b want %b%b", i, ackA, ackB, !expB, expB); end
        prevB   = expB;
        expData = expB ? 32'hB000_0000 + eB : 32'hA000_0000 + eA;
        if (expB) eB++; else eA++;
      end
      cyc();
      if (gotA) dataA = dataA + 1;
      if (gotB) dataB = dataB + 1;
      if (i == 3) begin reqA = 1'b0; reqB = 1'b0; end
    end
  endtask

  task automatic test_burst();
    logic [5:0] expBv;
    int         ownRR[6];
    int         ownFx[6];
    int         expOwn;
    do_reset();
    expBv = RR ? 6'b010000 : 6'b000000;
    ownRR = '{0, 1, 1, 1, 0, 0};
    ownFx = '{0, 1, 1, 1, 0, 1};
    reqA = 1'b1; lockA = 1'b1; addrA = 5'd4; dataA = 32'h100;
    reqB = 1'b1; lockB = 1'b0; addrB = 5'd5; dataB = 32'h200;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      expOwn = RR ? ownRR[i] : ownFx[i];
      compared++; if (ackA !== !expBv[i] || ackB !== expBv[i]) begin mismatched++; $display("FAIL burst_ack[%0d] got %b%b want %b%b", i, ackA, ackB, !expBv[i], expBv[i]); end
      compared++; if (owner !== 2'(expOwn)) begin mismatched++; $display("FAIL burst_owner[%0d] got %b want %0d", i, owner, expOwn); end
      cyc();
      dataA = dataA + 1;
    end
    clear_inputs();
  endtask

  task automatic test_r0();
    do_reset();
    reqB = 1'b1; addrB = 5'd0; dataB = 32'h1234_5678;
    @(negedge clk);
    compared++; if (ackB !== 1'b1 || ackA !== 1'b0) begin mismatched++; $display("FAIL r0_ack got %b%b want 01", ackA, ackB); end
    cyc();
    reqB = 1'b0;
    @(negedge clk);
    compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL r0_wr_en got %b want 0", wr_en); end
    compared++; if (sel !== 1'b1) begin mismatched++; $display("FAIL r0_sel got %b want 1", sel); end
    compared++; if (wr_data !== 32'h1234_5678) begin mismatched++; $display("FAIL r0_wr_data got %h want 12345678", wr_data); end
  endtask

  task automatic test_early_release();
    do_reset();
    reqB = 1'b1; lockB = 1'b1; addrB = 5'd9; dataB = 32'h55;
    @(negedge clk);
    compared++; if (ackB !== 1'b1 || owner !== 2'b00) begin mismatched++; $display("FAIL rel_enter got ackB=%b owner=%b want 1 00", ackB, owner); end
    cyc();
    dataB = 32'h56;
    reqA = 1'b1; lockA = 1'b0; addrA = 5'd3; dataA = 32'h77;
    @(negedge clk);
    compared++; if (ackB !== 1'b1 || ackA !== 1'b0) begin mismatched++; $display("FAIL rel_own_ack got %b%b want 01", ackA, ackB); end
    compared++; if (owner !== 2'b10) begin mismatched++; $display("FAIL rel_own_owner got %b want 10", owner); end
    cyc();
    reqB = 1'b0; lockB = 1'b0;
    @(negedge clk);
    compared++; if (ackA !== 1'b1 || ackB !== 1'b0) begin mismatched++; $display("FAIL rel_handover_ack got %b%b want 10", ackA, ackB); end
    cyc();
    reqA = 1'b0;
    @(negedge clk);
    compared++; if (owner !== 2'b00) begin mismatched++; $display("FAIL rel_owner got %b want 00", owner); end
    compared++; if (wr_en !== 1'b1 || sel !== 1'b0 || wr_data !== 32'h77) begin mismatched++; $display("FAIL rel_write got en=%b sel=%b data=%h want 1 0 77", wr_en, sel, wr_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    reqA = 1'b1; lockA = 1'b0; addrA = 5'd3; dataA = 32'h11;
    cyc();
    lockA = 1'b1; dataA = 32'h22;
    cyc();
    dataA = 32'h33;
    compared++; if (wr_en !== 1'b1 || owner !== 2'b01 || wr_data !== 32'h22) begin mismatched++; $display("FAIL arst_pre got en=%b owner=%b data=%h want 1 01 22", wr_en, owner, wr_data); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL arst_wr_en got %b want 0", wr_en); end
    compared++; if (wr_addr !== '0 || wr_data !== '0) begin mismatched++; $display("FAIL arst_wr_addr_data got %h %h want 0 0", wr_addr, wr_data); end
    compared++; if (sel !== 1'b0 || owner !== 2'b00) begin mismatched++; $display("FAIL arst_sel_owner got %b %b want 0 00", sel, owner); end
    compared++; if (ackA !== 1'b0 || ackB !== 1'b0) begin mismatched++; $display("FAIL arst_ack got %b%b want 00", ackA, ackB); end
    clear_inputs();
    cyc();
    compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL arst_cancel got %b want 0", wr_en); end
    rst_n = 1'b1;
    reqA = 1'b1; addrA = 5'd6; dataA = 32'h66;
    reqB = 1'b1; addrB = 5'd7; dataB = 32'h77;
    @(negedge clk);
    compared++; if (ackA !== 1'b1 || ackB !== 1'b0) begin mismatched++; $display("FAIL arst_first_tie got %b%b want 10", ackA, ackB); end
    cyc();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_r0();
    test_early_release();
    test_async_reset();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
